btn_debouncer: RTL and testbench

- Consumes one tap of the free-running divider count as its sample strobe.
- Turns the raw board push-buttons (cursor up/down/left/right, place-stone) into debounced levels and single-cycle press pulses.
- Provides auto-repeat on held cursor keys.
- Sits between the board pins and the game controller; every output is synchronous to the system clock.

---
 rtl/gobang_input_pkg.sv | 18 +
 rtl/btn_channel.sv | 119 +++++++++++
 rtl/btn_debouncer.sv | 60 ++++++
 tb/tb_btn_debouncer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gobang_input_pkg.sv
// Shared definitions for the board push-button input path.
package gobang_input_pkg;

    localparam int NUM_BTN   = 5;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_OK    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } chan_state_t;

endpackage

// File: rtl/btn_channel.sv
// One button channel: debounce counter, press/hold/repeat FSM and repeat counter.
module btn_channel
    import gobang_input_pkg::*;
#(
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sample,
    output logic level,
    output logic press
);

    localparam int DB_W    = $clog2(STABLE_CNT + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(STABLE_CNT - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] DELAY_FULL = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    chan_state_t      state, state_next;
    logic [DB_W-1:0]  db_cnt, db_cnt_next;
    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_next;
    logic             level_next;
    logic             press_next;

    // Debounce: count ticks whose sample disagrees with the accepted level and
    // flip the level on the tick where the disagreement run reaches STABLE_CNT.
    always_comb begin
        db_cnt_next = db_cnt;
        level_next  = level;
        if (tick) begin
            if (sample == level) begin
                db_cnt_next = '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt_next = '0;
                level_next  = ~level;
            end else begin
                db_cnt_next = db_cnt + 1'b1;
            end
        end
    end

    // Press/repeat FSM: a press pulse on acceptance, then timed repeat pulses
    // while held; a falling level always returns to IDLE silently.
    always_comb begin
        state_next   = state;
        rpt_cnt_next = rpt_cnt;
        press_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (level_next && !level) begin
                    press_next   = 1'b1;
                    rpt_cnt_next = '0;
                    state_next   = HOLD;
                end
            end
            HOLD: begin
                if (!level_next) begin
                    rpt_cnt_next = '0;
                    state_next   = IDLE;
                end else if (tick) begin
                    if (rpt_cnt == DELAY_LAST) begin
                        if (REPEAT_EN) begin
                            press_next   = 1'b1;
                            rpt_cnt_next = '0;
                            state_next   = REPEAT;
                        end else begin
                            rpt_cnt_next = DELAY_FULL;
                        end
                    end else if (rpt_cnt != DELAY_FULL) begin
                        rpt_cnt_next = rpt_cnt + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (!level_next) begin
                    rpt_cnt_next = '0;
                    state_next   = IDLE;
                end else if (tick) begin
                    if (rpt_cnt == RATE_LAST) begin
                        press_next   = 1'b1;
                        rpt_cnt_next = '0;
                    end else begin
                        rpt_cnt_next = rpt_cnt + 1'b1;
                    end
                end
            end
            default: begin
                rpt_cnt_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    // Channel state register; reset wins over everything, including REPEAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            db_cnt  <= '0;
            rpt_cnt <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            state   <= state_next;
            db_cnt  <= db_cnt_next;
            rpt_cnt <= rpt_cnt_next;
            level   <= level_next;
            press   <= press_next;
        end
    end

endmodule

// File: rtl/btn_debouncer.sv
// Push-button front end: synchronizes raw buttons and the divider tap, derives
// a one-cycle sample tick and feeds one independent channel per button.
module btn_debouncer
    import gobang_input_pkg::*;
#(
    parameter int                         NUM_BTN      = gobang_input_pkg::NUM_BTN,
    parameter int                         STABLE_CNT   = 4,
    parameter int                         REPEAT_DELAY = 32,
    parameter int                         REPEAT_RATE  = 8,
    parameter logic [NUM_BTN-1:0]         REPEAT_MASK  = 5'b01111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_src,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press
);

    logic [NUM_BTN-1:0] raw_meta, raw_sync;
    logic               tick_meta, tick_sync, tick_sync_d;
    logic               tick;

    // Two-flop synchronizers for the buttons and the divider tap, plus one
    // extra stage on the tap for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_meta    <= '0;
            raw_sync    <= '0;
            tick_meta   <= 1'b0;
            tick_sync   <= 1'b0;
            tick_sync_d <= 1'b0;
        end else begin
            raw_meta    <= btn_raw;
            raw_sync    <= raw_meta;
            tick_meta   <= tick_src;
            tick_sync   <= tick_meta;
            tick_sync_d <= tick_sync;
        end
    end

    assign tick = tick_sync & ~tick_sync_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_channel #(
            .STABLE_CNT   (STABLE_CNT),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .sample (raw_sync[i]),
            .level  (btn_level[i]),
            .press  (btn_press[i])
        );
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer: directed scenarios plus random button activity,
// all checked every cycle against a tick-counting behavioural model.
module tb_btn_debouncer;
    import gobang_input_pkg::*;

    localparam int                 N      = gobang_input_pkg::NUM_BTN;
    localparam int                 STABLE = 4;
    localparam int                 DELAY  = 32;
    localparam int                 RATE   = 8;
    localparam logic [N-1:0]       MASK   = 5'b01111;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_src = 1'b0;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press;

    int errors = 0;
    int checks = 0;

    // model state
    logic [N-1:0] mLevel, mPress;
    logic [N-1:0] r1, r2;
    logic         t1, t2, t3;
    int           mDiff [N];
    int           mHeld [N];
    int           tickNo = 0;

    // observation
    int pressCnt [N];
    int downTicks [$];
    bit tickHold = 1'b0;

    btn_debouncer #(
        .NUM_BTN      (N),
        .STABLE_CNT   (STABLE),
        .REPEAT_DELAY (DELAY),
        .REPEAT_RATE  (RATE),
        .REPEAT_MASK  (MASK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_src  (tick_src),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_press (btn_press)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the sample seen on a tick is the raw level two clocks earlier;
    // a level flips after STABLE disagreeing ticks; while held, press pulses
    // occur at 0 ticks after acceptance and at DELAY + k*RATE when masked in.
    task automatic stepModel();
        logic tk;
        if (rst) begin
            mLevel = '0; mPress = '0; r1 = '0; r2 = '0;
            t1 = 1'b0; t2 = 1'b0; t3 = 1'b0;
            for (int i = 0; i < N; i++) begin
                mDiff[i] = 0;
                mHeld[i] = -1;
            end
            return;
        end
        tk = t2 & ~t3;
        mPress = '0;
        if (tk) begin
            tickNo++;
            for (int i = 0; i < N; i++) begin
                if (r2[i] == mLevel[i]) begin
                    mDiff[i] = 0;
                    if (mLevel[i]) begin
                        mHeld[i]++;
                        if (MASK[i] && mHeld[i] >= DELAY && (mHeld[i] - DELAY) % RATE == 0)
                            mPress[i] = 1'b1;
                    end
                end else begin
                    mDiff[i]++;
                    if (mDiff[i] == STABLE) begin
                        mDiff[i]  = 0;
                        mLevel[i] = ~mLevel[i];
                        if (mLevel[i]) begin
                            mHeld[i]  = 0;
                            mPress[i] = 1'b1;
                        end else begin
                            mHeld[i] = -1;
                        end
                    end else if (mLevel[i]) begin
                        mHeld[i]++;
                        if (MASK[i] && mHeld[i] >= DELAY && (mHeld[i] - DELAY) % RATE == 0)
                            mPress[i] = 1'b1;
                    end
                end
            end
        end
        t3 = t2; t2 = t1; t1 = tick_src;
        r2 = r1; r1 = btn_raw;
    endtask

    // Compare process: advance the model on each edge, check on the falling edge.
    initial begin : compare
        for (int i = 0; i < N; i++) pressCnt[i] = 0;
        forever begin
            @(posedge clk);
            stepModel();
            @(negedge clk);
            checkOutput("btn_level", 32'(btn_level), 32'(mLevel));
            checkOutput("btn_press", 32'(btn_press), 32'(mPress));
            for (int i = 0; i < N; i++) pressCnt[i] += int'(btn_press[i]);
            if (btn_press[BTN_DOWN]) downTicks.push_back(tickNo);
        end
    end

    // Divider tap: one rising edge every 8 clocks unless forced high.
    initial begin : tickgen
        int cnt = 0;
        forever begin
            @(negedge clk);
            cnt++;
            if (tickHold) tick_src = 1'b1;
            else if (cnt % 4 == 0) tick_src = ~tick_src;
        end
    end

    task automatic applyStimulus(input logic [N-1:0] raw, input int nTicks);
        @(negedge clk);
        btn_raw = raw;
        repeat (nTicks * 8) @(negedge clk);
        #2;
    endtask

    initial begin : main
        int p;
        rst     = 1'b1;
        btn_raw = 5'b11111;

        // reset with every button pressed
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #2;
            checkOutput("reset_level", 32'(btn_level), 32'h0);
            checkOutput("reset_press", 32'(btn_press), 32'h0);
        end
        rst = 1'b0;
        btn_raw = '0;
        @(negedge clk); #2;
        checkOutput("post_reset_level", 32'(btn_level), 32'h0);
        checkOutput("post_reset_press", 32'(btn_press), 32'h0);

        // clean OK press, no repeat on this key
        p = pressCnt[BTN_OK];
        applyStimulus(5'b10000, 60);
        checkOutput("ok_level_held", 32'(btn_level[BTN_OK]), 32'h1);
        checkOutput("ok_press_count", 32'(pressCnt[BTN_OK] - p), 32'd1);
        applyStimulus(5'b00000, 6);
        checkOutput("ok_level_released", 32'(btn_level[BTN_OK]), 32'h0);

        // bouncing UP key
        p = pressCnt[BTN_UP];
        applyStimulus(5'b00001, 1);
        applyStimulus(5'b00000, 1);
        applyStimulus(5'b00001, 1);
        checkOutput("up_bounce_level", 32'(btn_level[BTN_UP]), 32'h0);
        checkOutput("up_bounce_press", 32'(pressCnt[BTN_UP] - p), 32'd0);
        applyStimulus(5'b00001, 8);
        checkOutput("up_level", 32'(btn_level[BTN_UP]), 32'h1);
        checkOutput("up_press_count", 32'(pressCnt[BTN_UP] - p), 32'd1);
        applyStimulus(5'b00000, 6);

        // DOWN auto-repeat: T, T+32, T+40, T+48, T+56
        downTicks.delete();
        applyStimulus(5'b00010, 62);
        checkOutput("down_pulse_count", 32'(downTicks.size()), 32'd5);
        if (downTicks.size() == 5) begin
            checkOutput("down_first_gap", 32'(downTicks[1] - downTicks[0]), 32'd32);
            checkOutput("down_gap2", 32'(downTicks[2] - downTicks[1]), 32'd8);
            checkOutput("down_gap3", 32'(downTicks[3] - downTicks[2]), 32'd8);
            checkOutput("down_gap4", 32'(downTicks[4] - downTicks[3]), 32'd8);
        end
        applyStimulus(5'b00000, 6);
        checkOutput("down_release_count", 32'(downTicks.size()), 32'd5);
        checkOutput("down_release_level", 32'(btn_level[BTN_DOWN]), 32'h0);

        // frozen divider tap with LEFT pressed
        p = pressCnt[BTN_LEFT];
        tickHold = 1'b1;
        @(negedge clk);
        btn_raw = 5'b00100;
        repeat (200) @(negedge clk);
        #2;
        checkOutput("frozen_level", 32'(btn_level[BTN_LEFT]), 32'h0);
        checkOutput("frozen_press", 32'(pressCnt[BTN_LEFT] - p), 32'd0);
        @(negedge clk);
        btn_raw  = '0;
        tickHold = 1'b0;
        applyStimulus(5'b00000, 6);

        // reset in the middle of RIGHT auto-repeat with the key still held
        applyStimulus(5'b01000, 45);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        p = pressCnt[BTN_RIGHT];
        @(negedge clk); #2;
        checkOutput("right_after_rst_level", 32'(btn_level), 32'h0);
        checkOutput("right_after_rst_press", 32'(btn_press), 32'h0);
        repeat (6 * 8) @(negedge clk);
        #2;
        checkOutput("right_relevel", 32'(btn_level[BTN_RIGHT]), 32'h1);
        checkOutput("right_fresh_press", 32'(pressCnt[BTN_RIGHT] - p), 32'd1);
        applyStimulus(5'b00000, 6);

        // random button activity with occasional resets
        repeat (2400) begin
            @(negedge clk);
            if ($urandom_range(63) == 0) btn_raw[$urandom_range(N - 1)] ^= 1'b1;
            rst = ($urandom_range(599) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
